// File: rtl/fpu_pkg.sv
// fpu_pkg: shared opcode, operand-class and IEEE 754 single-precision field constants
package fpu_pkg;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [2:0] CLS_NORMAL  = 3'b000;
    localparam logic [2:0] CLS_ZERO    = 3'b001;
    localparam logic [2:0] CLS_SUBNORM = 3'b010;
    localparam logic [2:0] CLS_INF     = 3'b011;
    localparam logic [2:0] CLS_NAN     = 3'b100;
    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
endpackage

// File: rtl/fpu_classify.sv
// fpu_classify: special-value class of a single-precision operand (sign ignored)
module fpu_classify
    import fpu_pkg::*;
(
    input  logic [31:0] num,
    output logic [2:0]  cls
);
    logic [EXP_W-1:0]  expo;
    logic [MANT_W-1:0] mant;
    assign expo = num[MANT_W +: EXP_W];
    assign mant = num[MANT_W-1:0];
    always_comb begin
        cls = (expo == '0) ? ((mant == '0) ? CLS_ZERO : CLS_SUBNORM) :
              (&expo)      ? ((mant == '0) ? CLS_INF  : CLS_NAN)     : CLS_NORMAL;
    end
endmodule

// File: rtl/fpu_issue_queue.sv
// fpu_issue_queue: DEPTH-entry valid/ready FIFO feeding the FPU with registered head outputs.
// Operand classification is stored per entry only when FPU_ISSUE_CLASSIFY_EN is defined.
module fpu_issue_queue
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_num1,
    input  logic [31:0]                in_num2,
    input  logic [3:0]                 in_op,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_num1,
    output logic [31:0]                out_num2,
    output logic [3:0]                 out_op,
    output logic [2:0]                 out_class1,
    output logic [2:0]                 out_class2,
    output logic                       out_unsup,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [31:0]   num1_q [DEPTH];
    logic [31:0]   num2_q [DEPTH];
    logic [3:0]    op_q   [DEPTH];
    logic          unsup_q[DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt, cnt_nxt;
    logic          alive, push, pop;

    // alive holds in_ready low until the first edge after reset is released
    assign in_ready  = alive && (cnt != FULL_CNT);
    assign out_valid = (cnt != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = cnt;

    always_comb begin
        cnt_nxt = (push && !pop) ? cnt + (AW+1)'(1) :
                  (pop && !push) ? cnt - (AW+1)'(1) : cnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            alive  <= 1'b0;
        end else begin
            alive  <= 1'b1;
            cnt    <= cnt_nxt;
            wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= pop  ? rd_ptr + AW'(1) : rd_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            num1_q[wr_ptr]  <= in_num1;
            num2_q[wr_ptr]  <= in_num2;
            op_q[wr_ptr]    <= in_op;
            unsup_q[wr_ptr] <= (in_op > OP_MUL);
        end
    end

    assign out_num1  = num1_q[rd_ptr];
    assign out_num2  = num2_q[rd_ptr];
    assign out_op    = op_q[rd_ptr];
    assign out_unsup = unsup_q[rd_ptr];

`ifdef FPU_ISSUE_CLASSIFY_EN
    logic [2:0] cls1, cls2;
    logic [5:0] cls_q[DEPTH];
    fpu_classify u_cls1 (.num(in_num1), .cls(cls1));
    fpu_classify u_cls2 (.num(in_num2), .cls(cls2));
    always_ff @(posedge clk) begin
        if (push) cls_q[wr_ptr] <= {cls1, cls2};
    end
    assign out_class1 = cls_q[rd_ptr][5:3];
    assign out_class2 = cls_q[rd_ptr][2:0];
`else
    assign out_class1 = 3'b000;
    assign out_class2 = 3'b000;
`endif
endmodule

// File: tb/tb_fpu_issue_queue.sv
// tb_fpu_issue_queue: directed table-driven bench plus fill/wrap, push+pop and async-reset sequences
module tb_fpu_issue_queue;
`ifdef FPU_ISSUE_CLASSIFY_EN
    localparam bit CLS_EN = 1'b1;
`else
    localparam bit CLS_EN = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_unsup;
    logic [31:0] in_num1 = '0, in_num2 = '0, out_num1, out_num2;
    logic [3:0]  in_op = '0, out_op;
    logic [2:0]  out_class1, out_class2;
    logic [2:0]  count;
    int          checks = 0, failures = 0;

    fpu_issue_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_num1(in_num1), .in_num2(in_num2), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_num1(out_num1),
        .out_num2(out_num2), .out_op(out_op), .out_class1(out_class1),
        .out_class2(out_class2), .out_unsup(out_unsup), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] n1, n2;
        logic [3:0]  op;
        logic [2:0]  c1, c2;
        logic        unsup;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] o);
        in_valid = v;
        in_num1  = a;
        in_num2  = b;
        in_op    = o;
    endtask

    vec_t        vecs[6];
    logic [31:0] model[$];

    initial begin
        vecs[0] = '{32'h0000_0000, 32'h0000_0000, 4'd0, 3'b001, 3'b001, 1'b0};
        vecs[1] = '{32'h0000_0001, 32'h7F80_0000, 4'd1, 3'b010, 3'b011, 1'b0};
        vecs[2] = '{32'h7FC0_0000, 32'hFF80_0000, 4'd3, 3'b100, 3'b011, 1'b1};
        vecs[3] = '{32'h3F80_0000, 32'h8000_0001, 4'd9, 3'b000, 3'b010, 1'b1};
        vecs[4] = '{32'hFF80_0000, 32'h8000_0000, 4'd2, 3'b011, 3'b001, 1'b0};
        vecs[5] = '{32'h7F80_0001, 32'h0080_0000, 4'd15, 3'b100, 3'b000, 1'b1};

        tick;
        tick;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        rst = 1'b0;
        tick;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // basic latency: push with out_ready=1, visible one edge later, popped the next
        out_ready = 1'b1;
        drive(1'b1, 32'h3F80_0000, 32'h4000_0000, 4'd2);
        tick;
        drive(1'b0, '0, '0, '0);
        chk("basic_valid", 32'(out_valid), 32'd1);
        chk("basic_num1", out_num1, 32'h3F80_0000);
        chk("basic_num2", out_num2, 32'h4000_0000);
        chk("basic_op", 32'(out_op), 32'd2);
        chk("basic_cls", 32'({out_class1, out_class2}), 32'd0);
        chk("basic_unsup", 32'(out_unsup), 32'd0);
        chk("basic_count1", 32'(count), 32'd1);
        tick;
        chk("basic_count0", 32'(count), 32'd0);
        chk("basic_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].n1, vecs[i].n2, vecs[i].op);
            tick;
            drive(1'b0, '0, '0, '0);
            tick;
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d_num1", i), out_num1, vecs[i].n1);
            chk($sformatf("v%0d_num2", i), out_num2, vecs[i].n2);
            chk($sformatf("v%0d_op", i), 32'(out_op), 32'(vecs[i].op));
            chk($sformatf("v%0d_cls1", i), 32'(out_class1), 32'(CLS_EN ? vecs[i].c1 : 3'b000));
            chk($sformatf("v%0d_cls2", i), 32'(out_class2), 32'(CLS_EN ? vecs[i].c2 : 3'b000));
            chk($sformatf("v%0d_unsup", i), 32'(out_unsup), 32'(vecs[i].unsup));
            out_ready = 1'b1;
            tick;
            out_ready = 1'b0;
            chk($sformatf("v%0d_count0", i), 32'(count), 32'd0);
        end

        // fill to full, reject a fifth, drain in order; second pass wraps the pointers
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 4; k++) begin
                drive(1'b1, 32'h100 * (p + 1) + k, ~(32'h100 * (p + 1) + k), 4'(k));
                tick;
            end
            chk($sformatf("fill%0d_count", p), 32'(count), 32'd4);
            chk($sformatf("fill%0d_in_ready", p), 32'(in_ready), 32'd0);
            drive(1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'd0);
            tick;
            drive(1'b0, '0, '0, '0);
            chk($sformatf("fill%0d_overflow", p), 32'(count), 32'd4);
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("drain%0d_%0d_num1", p, k), out_num1, 32'h100 * (p + 1) + k);
                chk($sformatf("drain%0d_%0d_num2", p, k), out_num2, ~(32'h100 * (p + 1) + k));
                chk($sformatf("drain%0d_%0d_op", p, k), 32'(out_op), 32'(k));
                out_ready = 1'b1;
                tick;
                out_ready = 1'b0;
            end
            chk($sformatf("drain%0d_empty", p), 32'(out_valid), 32'd0);
        end

        // steady push+pop at count=2 keeps occupancy and order
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 32'h300 + k, 32'h0, 4'd0);
            model.push_back(32'h300 + k);
            tick;
        end
        out_ready = 1'b1;
        for (int k = 2; k < 12; k++) begin
            drive(1'b1, 32'h300 + k, 32'h0, 4'd1);
            chk($sformatf("pp%0d_head", k), out_num1, model[0]);
            tick;
            void'(model.pop_front());
            model.push_back(32'h300 + k);
            chk($sformatf("pp%0d_count", k), 32'(count), 32'd2);
        end
        drive(1'b0, '0, '0, '0);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("pp_tail%0d", k), out_num1, model[0]);
            void'(model.pop_front());
            tick;
        end
        out_ready = 1'b0;
        chk("pp_empty", 32'(count), 32'd0);

        // asynchronous reset with three entries queued
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h400 + k, 32'h0, 4'd0);
            tick;
        end
        drive(1'b0, '0, '0, '0);
        chk("ar_pre_count", 32'(count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_out_valid", 32'(out_valid), 32'd0);
        chk("ar_count", 32'(count), 32'd0);
        chk("ar_in_ready", 32'(in_ready), 32'd0);
        tick;
        chk("ar_hold_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        tick;
        chk("ar_post_in_ready", 32'(in_ready), 32'd1);
        chk("ar_post_valid", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fpu_issue_queue.md
# fpu_issue_queue

Operand issue queue that sits directly upstream of the combinational FPU datapath. It accepts operation requests (two IEEE 754 single-precision operands plus a 4-bit opcode) over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. Each entry carries a per-operand special-value class and an unsupported-opcode tag. The head entry is presented on stable registered outputs that drive the FPU's `num1`/`num2`/`op` inputs for as long as the consumer takes to accept it.

## Interface
- DEPTH, 4, number of FIFO entries; power of two, ≥ 2
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  producer has a request
- in_ready  out  1  queue can accept; equals !full, forced 0 while rst=1
- in_num1  in  32  operand 1 (IEEE 754 single)
- in_num2  in  32  operand 2
- in_op  in  4  opcode: ADD=0, SUB=1, MUL=2, DIV=3
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer accepts head
- out_num1, out_num2  out  32 each  head operands
- out_op  out  4  head opcode
- out_class1, out_class2  out  3 each  head operand class
- out_unsup  out  1  head opcode is not ADD/SUB/MUL
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Push when in_valid && in_ready. Pop when out_valid && out_ready.
- Storage is an array indexed by wr_ptr/rd_ptr, each $clog2(DEPTH) bits. Pointers wrap naturally modulo DEPTH.
- count is incremented on push-only, decremented on pop-only, and unchanged on simultaneous push and pop.
- full = (count == DEPTH); empty = (count == 0).
- Simultaneous push and pop:
  - When not full and not empty, both occur.
  - When full, in_ready=0, so only the pop occurs.
  - When empty, only the push occurs. There is no bypass.
- out_unsup = 1 for any op other than 0, 1 or 2, including DIV (3) and codes 4–15. Such entries are still queued and issued, never dropped.
- Classification is computed at the write side and stored with the entry:
  - 000 normal (exp 1..254)
  - 001 zero (exp 0, mantissa 0)
  - 010 subnormal (exp 0, mantissa ≠ 0)
  - 011 infinity (exp 255, mantissa 0)
  - 100 NaN (exp 255, mantissa ≠ 0)
  - Sign is ignored.
- Out-of-range inputs need no handling: every 32-bit pattern maps to exactly one class.

## Timing
- Latency is 1 cycle. A push at edge N on an empty queue gives out_valid=1 after edge N.
- Throughput is 1 request per cycle while not full.
- Head outputs are driven from storage at rd_ptr and stay stable while out_valid=1 && out_ready=0.
- Data outputs are don't-care when out_valid=0. The bench checks them only when valid.
- Reset values (asynchronous, immediate): wr_ptr=0, rd_ptr=0, count=0, out_valid=0, in_ready=0 while rst=1 and 1 from the first cycle after deassertion. The storage array is not reset.
- Reset mid-operation discards all entries. No pop handshake is reported for the discarded entries.
- out_valid = !empty and depends only on registered state. in_ready = !full, also registered state only. There are no combinational in→out paths.

## Configuration
- FPU_ISSUE_CLASSIFY_EN defined:
  - Classifiers are instantiated.
  - 6 class bits are stored per entry.
  - out_class1/out_class2 carry the class of the head operands.
- Not defined:
  - No classifier logic and no class storage.
  - out_class1/out_class2 are tied to 3'b000.
- Ports are identical in both builds. out_unsup is always present.

## Structure
- Shared package fpu_pkg holds:
  - opcode localparams OP_ADD, OP_SUB, OP_MUL, OP_DIV
  - 3-bit class constants CLS_NORMAL, CLS_ZERO, CLS_SUBNORM, CLS_INF, CLS_NAN
  - field widths: EXP_W=8, MANT_W=23
- Sub-module fpu_classify: combinational, 32-bit in, 3-bit class out. Instantiated twice (one per operand) under FPU_ISSUE_CLASSIFY_EN.

## Test plan
- Reset, then push {0x3F800000, 0x40000000, op=2}, with out_ready=1 → out_valid=1 next cycle, out_num1=0x3F800000, out_num2=0x40000000, out_op=2, class 000/000, out_unsup=0, count 1→0.
- Push 4 entries with out_ready=0, DEPTH=4 → count=4 and in_ready=0. A 5th in_valid is ignored. Popping all 4 returns them in FIFO order, and pointers wrap correctly on a second pass of 4.
- With count=2, hold push and pop in the same cycle for 10 cycles → count stays 2 and data order is preserved.
- Push operand pairs 0x00000000, 0x00000001, 0x7F800000, 0x7FC00000, 0xFF800000 → classes 001, 010, 011, 100, 011 with the macro defined; all 000 without it.
- Push op=3 and op=9 → both issued with out_unsup=1; op=0 and op=1 → out_unsup=0.
- Assert rst asynchronously with 3 entries queued → out_valid=0 and count=0 immediately, in_ready=0 during reset and 1 after deassertion.
